// File: rtl/chan_word_collector_pkg.sv
// Shared configuration, FSM state type and FIFO entry layout for the
// per-channel serial word collector.
package chan_word_collector_pkg;

    localparam int NCH        = 4;
    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;

    localparam int CW   = $clog2(NCH);
    localparam int LW   = $clog2(WORD_W + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [CW-1:0]     ch;
        logic              partial;
        logic [LW-1:0]     len;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/chan_word_collector_fifo.sv
// Synchronous FIFO with combinational head read; a push into a full FIFO
// succeeds when a pop happens in the same cycle.
module cwc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    wdata,
    input  logic            pop,
    output logic [W-1:0]    rdata,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNTW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/chan_word_collector.sv
// Rebuilds WORD_W-bit words per channel from a tagged serial bit stream and
// queues them (plus partial words flushed at frame end) in a shared FIFO.
module chan_word_collector
    import chan_word_collector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_valid,
    input  logic [CW-1:0]     ser_ch,
    input  logic              ser_bit,
    input  logic              frame_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_partial,
    output logic [LW-1:0]     out_len,
    output logic [CNTW-1:0]   fifo_count,
    output logic              busy,
    output logic              overflow,
    output logic              proto_err,
    input  logic              clr_err
);

    state_e            state_q, state_d;
    logic [CW-1:0]     scan_q, scan_d;
    logic [WORD_W-1:0] sr_q   [NCH];
    logic [WORD_W-1:0] sr_d   [NCH];
    logic [LW-1:0]     fill_q [NCH];
    logic [LW-1:0]     fill_d [NCH];
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;

    logic        push, pop, can_push, more, ovf_set, perr_set;
    logic        fifo_full, fifo_empty;
    fifo_entry_t push_entry, head;

    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        push       = 1'b0;
        push_entry = '0;
        ovf_set    = 1'b0;
        perr_set   = 1'b0;
        pop        = out_ready && !fifo_empty;
        can_push   = !fifo_full || pop;

        // Any non-empty channel left above the scan pointer keeps FLUSH alive.
        more = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (i > int'(scan_q) && fill_q[i] != '0) more = 1'b1;
        end

        case (state_q)
            IDLE, COLLECT: begin
                if (ser_valid) begin
                    if (state_q == IDLE) state_d = COLLECT;
                    if (fill_q[ser_ch] == LW'(WORD_W - 1)) begin
                        sr_d[ser_ch]   = '0;
                        fill_d[ser_ch] = '0;
                        if (can_push) begin
                            push       = 1'b1;
                            push_entry = '{ch: ser_ch, partial: 1'b0, len: LW'(WORD_W),
                                           data: {sr_q[ser_ch][WORD_W-2:0], ser_bit}};
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end else begin
                        sr_d[ser_ch]   = {sr_q[ser_ch][WORD_W-2:0], ser_bit};
                        fill_d[ser_ch] = fill_q[ser_ch] + LW'(1);
                    end
                end
                if (state_q == COLLECT && frame_done) begin
                    state_d = FLUSH;
                    scan_d  = '0;
                end
            end
            FLUSH: begin
                perr_set = ser_valid;
                if (fill_q[scan_q] == '0 || can_push) begin
                    if (fill_q[scan_q] != '0) begin
                        push           = 1'b1;
                        push_entry     = '{ch: scan_q, partial: 1'b1, len: fill_q[scan_q],
                                           data: sr_q[scan_q]};
                        sr_d[scan_q]   = '0;
                        fill_d[scan_q] = '0;
                    end
                    scan_d = scan_q + CW'(1);
                    if (!more) begin
                        state_d = IDLE;
                        scan_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        overflow_d  = ovf_set  || (overflow_q  && !clr_err);
        proto_err_d = perr_set || (proto_err_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                sr_q[i]   <= '0;
                fill_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
        end
    end

    cwc_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = head.data;
    assign out_ch      = head.ch;
    assign out_partial = head.partial;
    assign out_len     = head.len;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_chan_word_collector.sv
// Directed, table-driven bench for chan_word_collector: word assembly,
// partial flush, overflow, FIFO stall during flush and protocol errors.
module tb_chan_word_collector;
    import chan_word_collector_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ser_valid = 1'b0;
    logic [CW-1:0]     ser_ch = '0;
    logic              ser_bit = 1'b0;
    logic              frame_done = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic [CW-1:0]     out_ch;
    logic              out_partial;
    logic [LW-1:0]     out_len;
    logic [CNTW-1:0]   fifo_count;
    logic              busy;
    logic              overflow;
    logic              proto_err;
    logic              clr_err = 1'b0;

    int n_compared = 0;
    int n_failed   = 0;

    chan_word_collector dut (
        .clk         (clk),
        .rst         (rst),
        .ser_valid   (ser_valid),
        .ser_ch      (ser_ch),
        .ser_bit     (ser_bit),
        .frame_done  (frame_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_partial (out_partial),
        .out_len     (out_len),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .proto_err   (proto_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0]     ch;
        logic [WORD_W-1:0] word;
        int                nbits;
        logic              flush;
        logic [WORD_W-1:0] exp_data;
        logic              exp_partial;
        int                exp_len;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [CW-1:0] ch, input logic b);
        ser_valid = 1'b1;
        ser_ch    = ch;
        ser_bit   = b;
        @(posedge clk); #1;
        ser_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [CW-1:0] ch, input logic [WORD_W-1:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) apply_stimulus(ch, word[i]);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_frame_done();
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, busy, 0);
    endtask

    task automatic check_head(input string name, input logic [WORD_W-1:0] data, input logic [CW-1:0] ch,
                              input logic partial, input int len);
        check_output({name, "_valid"}, out_valid, 1);
        check_output({name, "_data"}, out_data, data);
        check_output({name, "_ch"}, out_ch, ch);
        check_output({name, "_partial"}, out_partial, partial);
        check_output({name, "_len"}, out_len, len);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{ch: 2'd2, word: 8'hB2, nbits: 8, flush: 1'b0, exp_data: 8'hB2, exp_partial: 1'b0, exp_len: 8};
        vecs[1] = '{ch: 2'd0, word: 8'hFF, nbits: 8, flush: 1'b0, exp_data: 8'hFF, exp_partial: 1'b0, exp_len: 8};
        vecs[2] = '{ch: 2'd3, word: 8'h06, nbits: 3, flush: 1'b1, exp_data: 8'h06, exp_partial: 1'b1, exp_len: 3};
        vecs[3] = '{ch: 2'd1, word: 8'h01, nbits: 1, flush: 1'b1, exp_data: 8'h01, exp_partial: 1'b1, exp_len: 1};
        vecs[4] = '{ch: 2'd0, word: 8'h7F, nbits: 7, flush: 1'b1, exp_data: 8'h7F, exp_partial: 1'b1, exp_len: 7};
        vecs[5] = '{ch: 2'd1, word: 8'h00, nbits: 8, flush: 1'b0, exp_data: 8'h00, exp_partial: 1'b0, exp_len: 8};

        // Reset held while ser_valid toggles: everything must stay quiet.
        for (int i = 0; i < 4; i++) begin
            ser_valid = ~ser_valid;
            ser_bit   = 1'b1;
            @(posedge clk); #1;
            check_output("rst_busy", busy, 0);
            check_output("rst_valid", out_valid, 0);
        end
        ser_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("post_rst_busy", busy, 0);
        check_output("post_rst_valid", out_valid, 0);
        check_output("post_rst_data", out_data, 0);
        check_output("post_rst_ch", out_ch, 0);
        check_output("post_rst_partial", out_partial, 0);
        check_output("post_rst_len", out_len, 0);
        check_output("post_rst_count", fifo_count, 0);
        check_output("post_rst_ovf", overflow, 0);
        check_output("post_rst_perr", proto_err, 0);

        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].ch, vecs[v].word, vecs[v].nbits);
            if (vecs[v].flush) begin
                check_output("vec_busy_pre_flush", busy, 1);
                pulse_frame_done();
                wait_idle("vec_flush_done", 20);
            end
            check_head("vec_head", vecs[v].exp_data, vecs[v].ch, vecs[v].exp_partial, vecs[v].exp_len);
            check_output("vec_count", fifo_count, 1);
            pop_one();
            check_output("vec_count_after_pop", fifo_count, 0);
        end

        // Two channels interleaved bit by bit.
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a, b;
            a = 8'hA5;
            b = 8'h3C;
            apply_stimulus(2'd0, a[i]);
            apply_stimulus(2'd1, b[i]);
        end
        check_output("ilv_count", fifo_count, 2);
        check_head("ilv_first", 8'hA5, 2'd0, 1'b0, 8);
        pop_one();
        check_head("ilv_second", 8'h3C, 2'd1, 1'b0, 8);
        pop_one();
        check_output("ilv_count_end", fifo_count, 0);

        // Five words into a four-entry FIFO with no consumer.
        send_bits(2'd2, 8'h11, 8);
        send_bits(2'd2, 8'h22, 8);
        send_bits(2'd2, 8'h33, 8);
        send_bits(2'd2, 8'h44, 8);
        check_output("ovf_not_yet", overflow, 0);
        send_bits(2'd2, 8'h55, 8);
        check_output("ovf_count", fifo_count, 4);
        check_output("ovf_flag", overflow, 1);
        pulse_clr();
        check_output("ovf_cleared", overflow, 0);
        check_head("ovf_d0", 8'h11, 2'd2, 1'b0, 8); pop_one();
        check_head("ovf_d1", 8'h22, 2'd2, 1'b0, 8); pop_one();
        check_head("ovf_d2", 8'h33, 2'd2, 1'b0, 8); pop_one();
        check_head("ovf_d3", 8'h44, 2'd2, 1'b0, 8); pop_one();
        check_output("ovf_drained", fifo_count, 0);

        // Word completing into a full FIFO while a pop happens the same cycle.
        send_bits(2'd1, 8'hA1, 8);
        send_bits(2'd1, 8'hA2, 8);
        send_bits(2'd1, 8'hA3, 8);
        send_bits(2'd1, 8'hA4, 8);
        send_bits(2'd1, 8'h52, 7);
        out_ready = 1'b1;
        apply_stimulus(2'd1, 1'b1);
        out_ready = 1'b0;
        check_output("fullpop_count", fifo_count, 4);
        check_output("fullpop_ovf", overflow, 0);
        check_head("fullpop_h0", 8'hA2, 2'd1, 1'b0, 8); pop_one();
        check_head("fullpop_h1", 8'hA3, 2'd1, 1'b0, 8); pop_one();
        check_head("fullpop_h2", 8'hA4, 2'd1, 1'b0, 8); pop_one();
        check_head("fullpop_h3", 8'hA5, 2'd1, 1'b0, 8); pop_one();

        // ser_valid while flushing: flagged and the bit never lands.
        send_bits(2'd1, 8'h02, 2);
        send_bits(2'd3, 8'h05, 3);
        pulse_frame_done();
        check_output("perr_in_flush", busy, 1);
        apply_stimulus(2'd0, 1'b1);
        check_output("perr_flag", proto_err, 1);
        wait_idle("perr_flush_done", 20);
        check_output("perr_count", fifo_count, 2);
        check_head("perr_h0", 8'h02, 2'd1, 1'b1, 2); pop_one();
        check_head("perr_h1", 8'h05, 2'd3, 1'b1, 3); pop_one();
        check_output("perr_sticky", proto_err, 1);
        pulse_clr();
        check_output("perr_cleared", proto_err, 0);

        // Flush stalls on a full FIFO until the consumer frees an entry.
        send_bits(2'd0, 8'h10, 8);
        send_bits(2'd0, 8'h20, 8);
        send_bits(2'd0, 8'h30, 8);
        send_bits(2'd0, 8'h40, 8);
        send_bits(2'd2, 8'h03, 2);
        pulse_frame_done();
        repeat (6) @(posedge clk);
        #1;
        check_output("stall_busy", busy, 1);
        check_output("stall_count", fifo_count, 4);
        pop_one();
        check_output("stall_count_after", fifo_count, 4);
        wait_idle("stall_done", 5);
        check_head("stall_h0", 8'h20, 2'd0, 1'b0, 8); pop_one();
        check_head("stall_h1", 8'h30, 2'd0, 1'b0, 8); pop_one();
        check_head("stall_h2", 8'h40, 2'd0, 1'b0, 8); pop_one();
        check_head("stall_h3", 8'h03, 2'd2, 1'b1, 2); pop_one();
        check_output("stall_drained", fifo_count, 0);
        check_output("stall_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
